// File: rtl/bilinear_fetch.sv
// Raster-order bilinear neighbour fetch: four 1-cycle RAM reads per destination pixel, tuple out via valid/ready.
// out_valid rises 5 cycles after leaving IDLE/ADV; while out_ready is low the tuple holds and no reads are issued.
module bilinear_fetch #(
   parameter int DIM_W  = 10,
   parameter int ADDR_W = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  src_w,
   input  logic [DIM_W-1:0]  src_h,
   input  logic [DIM_W-1:0]  dst_w,
   input  logic [DIM_W-1:0]  dst_h,
   input  logic [15:0]       step_x,
   input  logic [15:0]       step_y,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        p00,
   output logic [7:0]        p10,
   output logic [7:0]        p01,
   output logic [7:0]        p11,
   output logic [15:0]       fx,
   output logic [15:0]       fy,
   output logic [DIM_W-1:0]  out_x,
   output logic [DIM_W-1:0]  out_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam int ACC_W = DIM_W + 8;
   localparam logic [DIM_W-1:0] ONE_D = 1;

   typedef enum logic [3:0] {IDLE, RD00, RD10, RD01, RD11, CAP, OUT, ADV, FIN} state_t;
   state_t state;

   logic [DIM_W-1:0]  src_w_r, src_h_r, dst_w_r, dst_h_r;
   logic [15:0]       step_x_r, step_y_r;
   logic [ADDR_W-1:0] base_r;
   logic [ACC_W-1:0]  acc_x, acc_y;

   logic [ACC_W-1:0]  acc_x_nxt, acc_y_nxt;
   logic [DIM_W-1:0]  sw, sh, ix, iy, lim_x, lim_y;
   logic [DIM_W-1:0]  x0, x1, y0, y1, rd_x, rd_y;
   logic [ADDR_W-1:0] base_sel, rd_addr;
   logic [2*DIM_W-1:0] row_off;
   logic              row_end, last_tuple;

   assign row_end    = (out_x == dst_w_r - ONE_D);
   assign last_tuple = row_end && (out_y == dst_h_r - ONE_D);

   // acc_*_nxt is the accumulator value the next read will use; RD00 is
   // addressed on the same edge that clears or advances the accumulators.
   always_comb begin
      acc_x_nxt = acc_x;
      acc_y_nxt = acc_y;
      if (state == IDLE) begin
         acc_x_nxt = '0;
         acc_y_nxt = '0;
      end else if (state == ADV) begin
         if (row_end) begin
            acc_x_nxt = '0;
            acc_y_nxt = acc_y + ACC_W'(step_y_r);
         end else begin
            acc_x_nxt = acc_x + ACC_W'(step_x_r);
         end
      end
   end

   assign sw       = (state == IDLE) ? src_w : src_w_r;
   assign sh       = (state == IDLE) ? src_h : src_h_r;
   assign base_sel = (state == IDLE) ? base_addr : base_r;

   assign ix    = acc_x_nxt[ACC_W-1:8];
   assign iy    = acc_y_nxt[ACC_W-1:8];
   assign lim_x = sw - ONE_D;
   assign lim_y = sh - ONE_D;
   assign x0    = (ix >= lim_x) ? lim_x : ix;
   assign x1    = (ix >= lim_x) ? lim_x : ix + ONE_D;
   assign y0    = (iy >= lim_y) ? lim_y : iy;
   assign y1    = (iy >= lim_y) ? lim_y : iy + ONE_D;

   always_comb begin
      rd_x = x0;
      rd_y = y0;
      case (state)
         RD00: begin rd_x = x1; rd_y = y0; end
         RD10: begin rd_x = x0; rd_y = y1; end
         RD01: begin rd_x = x1; rd_y = y1; end
         default: begin rd_x = x0; rd_y = y0; end
      endcase
   end

   assign row_off = {{DIM_W{1'b0}}, rd_y} * {{DIM_W{1'b0}}, sw};
   assign rd_addr = base_sel + ADDR_W'(row_off) + ADDR_W'(rd_x);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         src_w_r   <= '0;
         src_h_r   <= '0;
         dst_w_r   <= '0;
         dst_h_r   <= '0;
         step_x_r  <= '0;
         step_y_r  <= '0;
         base_r    <= '0;
         acc_x     <= '0;
         acc_y     <= '0;
         mem_rd    <= 1'b0;
         mem_addr  <= '0;
         p00       <= '0;
         p10       <= '0;
         p01       <= '0;
         p11       <= '0;
         fx        <= '0;
         fy        <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done   <= 1'b0;
         mem_rd <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  src_w_r  <= src_w;
                  src_h_r  <= src_h;
                  dst_w_r  <= dst_w;
                  dst_h_r  <= dst_h;
                  step_x_r <= step_x;
                  step_y_r <= step_y;
                  base_r   <= base_addr;
                  acc_x    <= '0;
                  acc_y    <= '0;
                  out_x    <= '0;
                  out_y    <= '0;
                  busy     <= 1'b1;
                  if (dst_w == '0 || dst_h == '0) begin
                     state <= FIN;
                  end else begin
                     mem_rd   <= 1'b1;
                     mem_addr <= rd_addr;
                     state    <= RD00;
                  end
               end
            end
            RD00: begin
               mem_rd   <= 1'b1;
               mem_addr <= rd_addr;
               state    <= RD10;
            end
            RD10: begin
               p00      <= mem_rdata;
               mem_rd   <= 1'b1;
               mem_addr <= rd_addr;
               state    <= RD01;
            end
            RD01: begin
               p10      <= mem_rdata;
               mem_rd   <= 1'b1;
               mem_addr <= rd_addr;
               state    <= RD11;
            end
            RD11: begin
               p01   <= mem_rdata;
               state <= CAP;
            end
            CAP: begin
               p11       <= mem_rdata;
               fx        <= {8'h00, acc_x[7:0]};
               fy        <= {8'h00, acc_y[7:0]};
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ADV;
               end
            end
            ADV: begin
               acc_x <= acc_x_nxt;
               acc_y <= acc_y_nxt;
               if (row_end) begin
                  out_x <= '0;
                  out_y <= out_y + ONE_D;
               end else begin
                  out_x <= out_x + ONE_D;
               end
               if (last_tuple) begin
                  state <= FIN;
               end else begin
                  mem_rd   <= 1'b1;
                  mem_addr <= rd_addr;
                  state    <= RD00;
               end
            end
            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bilinear_fetch.sv
// Directed bench for bilinear_fetch: small source frames in a 1-cycle-latency RAM model, hand-computed tuples.
module tb_bilinear_fetch;

   localparam int DIM_W  = 10;
   localparam int ADDR_W = 20;

   logic              clk = 1'b0;
   logic              rst, start, out_ready;
   logic [DIM_W-1:0]  src_w, src_h, dst_w, dst_h;
   logic [15:0]       step_x, step_y;
   logic [ADDR_W-1:0] base_addr;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [7:0]        p00, p10, p01, p11;
   logic [15:0]       fx, fy;
   logic [DIM_W-1:0]  out_x, out_y;
   logic              out_valid, busy, done;

   logic [7:0] ram [0:1023];
   int vec = 0;
   int errs = 0;
   int rd_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   bilinear_fetch #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .src_w(src_w), .src_h(src_h), .dst_w(dst_w), .dst_h(dst_h),
      .step_x(step_x), .step_y(step_y), .base_addr(base_addr),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .p00(p00), .p10(p10), .p01(p01), .p11(p11),
      .fx(fx), .fy(fy), .out_x(out_x), .out_y(out_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always @(posedge clk) begin
      if (mem_rd) begin
         mem_rdata <= ram[mem_addr[9:0]];
         rd_cnt    <= rd_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_frame(input int sw, input int sh, input int dw, input int dh,
                              input int sx, input int sy, input int base);
      @(negedge clk);
      src_w = DIM_W'(sw); src_h = DIM_W'(sh); dst_w = DIM_W'(dw); dst_h = DIM_W'(dh);
      step_x = 16'(sx); step_y = 16'(sy); base_addr = ADDR_W'(base);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // scramble the inputs: the frame must run from the latched copies
      src_w = 10'd9; src_h = 10'd9; dst_w = 10'd1; dst_h = 10'd1;
      step_x = 16'h0100; step_y = 16'h0100; base_addr = '0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   task automatic check_tuple(input string tag, input int ex, input int ey,
                              input int e00, input int e10, input int e01, input int e11,
                              input int efx, input int efy);
      chk($sformatf("%s.x", tag),   32'(out_x), 32'(ex));
      chk($sformatf("%s.y", tag),   32'(out_y), 32'(ey));
      chk($sformatf("%s.p00", tag), 32'(p00),   32'(e00));
      chk($sformatf("%s.p10", tag), 32'(p10),   32'(e10));
      chk($sformatf("%s.p01", tag), 32'(p01),   32'(e01));
      chk($sformatf("%s.p11", tag), 32'(p11),   32'(e11));
      chk($sformatf("%s.fx", tag),  32'(fx),    32'(efx));
      chk($sformatf("%s.fy", tag),  32'(fy),    32'(efy));
   endtask

   task automatic take(input string tag, input int ex, input int ey,
                       input int e00, input int e10, input int e01, input int e11,
                       input int efx, input int efy);
      int n;
      wait_valid(n);
      check_tuple(tag, ex, ey, e00, e10, e01, e11, efx, efy);
      @(negedge clk);
   endtask

   initial begin
      int lat, r0, d0;
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      src_w = '0; src_h = '0; dst_w = '0; dst_h = '0;
      step_x = '0; step_y = '0; base_addr = '0;
      for (int i = 0; i < 1024; i++) ram[i] = 8'hEE;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            ram[32'h40 + 4*y + x] = 8'(16*y + x);
      ram[10'h200] = 8'd10; ram[10'h201] = 8'd20;
      ram[10'h202] = 8'd30; ram[10'h203] = 8'd40;

      repeat (3) @(negedge clk);
      chk("rst.busy",      {31'd0, busy},      32'd0);
      chk("rst.done",      {31'd0, done},      32'd0);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.mem_rd",    {31'd0, mem_rd},    32'd0);
      chk("rst.mem_addr",  32'(mem_addr),      32'd0);
      chk("rst.p00",       32'(p00),           32'd0);
      rst = 1'b0;

      // 4x4 source, 2x2 destination, integer step 2, backpressure on first tuple
      out_ready = 1'b0;
      r0 = rd_cnt; d0 = done_cnt;
      start_frame(4, 4, 2, 2, 16'h0200, 16'h0200, 32'h40);
      wait_valid(lat);
      chk("t1.latency", 32'(lat), 32'd5);
      check_tuple("t1.00", 0, 0, 8'h00, 8'h01, 8'h10, 8'h11, 0, 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp.valid", {31'd0, out_valid}, 32'd1);
         chk("bp.p11",   32'(p11),           32'h11);
      end
      chk("bp.no_reads", 32'(rd_cnt - r0), 32'd4);
      out_ready = 1'b1;
      @(negedge clk);
      take("t1.10", 1, 0, 8'h02, 8'h03, 8'h12, 8'h13, 0, 0);
      take("t1.01", 0, 1, 8'h20, 8'h21, 8'h30, 8'h31, 0, 0);
      take("t1.11", 1, 1, 8'h22, 8'h23, 8'h32, 8'h33, 0, 0);
      wait_done("t1.done");
      repeat (3) @(negedge clk);
      chk("t1.done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("t1.rd_cnt",   32'(rd_cnt - r0),   32'd16);
      chk("t1.busy",     {31'd0, busy},      32'd0);

      // fractional step 1.5
      start_frame(4, 4, 2, 2, 16'h0180, 16'h0180, 32'h40);
      take("t2.00", 0, 0, 8'h00, 8'h01, 8'h10, 8'h11, 16'h0000, 16'h0000);
      take("t2.10", 1, 0, 8'h01, 8'h02, 8'h11, 8'h12, 16'h0080, 16'h0000);
      take("t2.01", 0, 1, 8'h10, 8'h11, 8'h20, 8'h21, 16'h0000, 16'h0080);
      take("t2.11", 1, 1, 8'h11, 8'h12, 8'h21, 8'h22, 16'h0080, 16'h0080);
      wait_done("t2.done");

      // 2x2 source upscaled to 3x3: right/bottom edges clamp
      start_frame(2, 2, 3, 3, 16'h00AA, 16'h00AA, 32'h200);
      take("t3.00", 0, 0, 10, 20, 30, 40, 16'h00, 16'h00);
      take("t3.10", 1, 0, 10, 20, 30, 40, 16'hAA, 16'h00);
      take("t3.20", 2, 0, 20, 20, 40, 40, 16'h54, 16'h00);
      take("t3.01", 0, 1, 10, 20, 30, 40, 16'h00, 16'hAA);
      take("t3.11", 1, 1, 10, 20, 30, 40, 16'hAA, 16'hAA);
      take("t3.21", 2, 1, 20, 20, 40, 40, 16'h54, 16'hAA);
      take("t3.02", 0, 2, 30, 40, 30, 40, 16'h00, 16'h54);
      take("t3.12", 1, 2, 30, 40, 30, 40, 16'hAA, 16'h54);
      take("t3.22", 2, 2, 40, 40, 40, 40, 16'h54, 16'h54);
      wait_done("t3.done");

      // reset mid-frame after two tuples, then rerun
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      start_frame(4, 4, 2, 2, 16'h0200, 16'h0200, 32'h40);
      take("t4.00", 0, 0, 8'h00, 8'h01, 8'h10, 8'h11, 0, 0);
      take("t4.10", 1, 0, 8'h02, 8'h03, 8'h12, 8'h13, 0, 0);
      chk("t4.busy_before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("t4.busy",  {31'd0, busy},      32'd0);
      chk("t4.valid", {31'd0, out_valid}, 32'd0);
      chk("t4.mem_rd",{31'd0, mem_rd},    32'd0);
      chk("t4.addr",  32'(mem_addr),      32'd0);
      chk("t4.p11",   32'(p11),           32'd0);
      chk("t4.fxfy",  {fx, fy},           32'd0);
      chk("t4.xy",    32'({out_x, out_y}),32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("t4.no_done", 32'(done_cnt - d0), 32'd0);
      start_frame(4, 4, 2, 2, 16'h0200, 16'h0200, 32'h40);
      wait_valid(lat);
      chk("t4.relat", 32'(lat), 32'd5);
      take("t4r.00", 0, 0, 8'h00, 8'h01, 8'h10, 8'h11, 0, 0);
      take("t4r.10", 1, 0, 8'h02, 8'h03, 8'h12, 8'h13, 0, 0);
      take("t4r.01", 0, 1, 8'h20, 8'h21, 8'h30, 8'h31, 0, 0);
      take("t4r.11", 1, 1, 8'h22, 8'h23, 8'h32, 8'h33, 0, 0);
      wait_done("t4.done");
      repeat (3) @(negedge clk);
      chk("t4.done_cnt", 32'(done_cnt - d0), 32'd1);

      // empty destination; start held into the busy cycle must be ignored
      r0 = rd_cnt; d0 = done_cnt;
      @(negedge clk);
      src_w = 10'd4; src_h = 10'd4; dst_w = 10'd0; dst_h = 10'd2;
      start = 1'b1;
      @(negedge clk);
      chk("t5.busy1", {31'd0, busy}, 32'd1);
      chk("t5.done1", {31'd0, done}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("t5.done2", {31'd0, done}, 32'd1);
      chk("t5.busy2", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("t5.done3", {31'd0, done}, 32'd0);
      repeat (6) @(negedge clk);
      chk("t5.done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("t5.no_reads", 32'(rd_cnt - r0),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
